alu_cmd_sequencer: RTL and testbench

Two-requester command controller sitting in front of the registered arithmetic unit in the ALU top. It arbitrates round-robin between two operation requesters and issues each granted command to the unit as a single-cycle enable pulse. It captures the registered result when the unit's flag rises and returns it through a held valid/ready response channel. Divide-by-zero is trapped before issue, and a watchdog covers a unit that never raises its flag.

---
 rtl/alu_cmd_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_alu_cmd_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_cmd_sequencer.sv
// -----------------------------------------------------------------------------
// alu_cmd_sequencer
//
// Command controller in front of the registered arithmetic unit. It arbitrates
// round-robin between two requesters and issues each granted command to the
// unit as a one-cycle alu_en pulse. It captures the unit result when alu_flag
// rises and returns it on a held valid/ready response channel. Divide-by-zero
// is trapped before issue. A watchdog turns a missing alu_flag into an error
// response.
//
// Parameters
//   WIDTH    operand/result width (matches the unit's in/out width)
//   TMO_CYC  WAIT cycles without alu_flag before a timeout error is returned
//
// Ports
//   clk, rst                      clock, asynchronous active-low reset
//   reqN_valid/reqN_ready         command handshake for requester N (0/1)
//   reqN_fun, reqN_a, reqN_b      op (00 add, 01 sub, 10 mul, 11 div), operands
//   alu_en, alu_fun, alu_a/b      one-cycle enable and registered command
//   alu_out, alu_carry, alu_flag  unit result, carry/borrow, result-valid
//   rsp_valid/rsp_ready           response handshake, valid held until taken
//   rsp_id, rsp_data, rsp_carry   requester index, result, carry
//   rsp_err                       1 = divide-by-zero or timeout
// -----------------------------------------------------------------------------
module alu_cmd_sequencer #(
    parameter int WIDTH   = 16,
    parameter int TMO_CYC = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [1:0]       req0_fun,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [1:0]       req1_fun,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             alu_en,
    output logic [1:0]       alu_fun,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_carry,
    input  logic             alu_flag,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [WIDTH-1:0] rsp_data,
    output logic             rsp_carry,
    output logic             rsp_err
);

    localparam int TMO_W = (TMO_CYC > 1) ? $clog2(TMO_CYC) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;
    logic               last_grant;
    logic [TMO_W-1:0]   tmo_cnt;

    logic               grant;
    logic               accept;
    logic [1:0]         sel_fun;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               div_zero;
    logic               tmo_last;

    // On a tie the requester that was not granted last wins; otherwise the
    // single valid requester wins.
    always_comb begin
        grant = 1'b0;
        if (req0_valid && req1_valid) begin
            grant = ~last_grant;
        end else if (req1_valid) begin
            grant = 1'b1;
        end
    end

    assign accept     = (state == IDLE) && (req0_valid || req1_valid);
    assign req0_ready = (state == IDLE) && req0_valid && !grant;
    assign req1_ready = (state == IDLE) && req1_valid && grant;

    assign sel_fun  = grant ? req1_fun : req0_fun;
    assign sel_a    = grant ? req1_a   : req0_a;
    assign sel_b    = grant ? req1_b   : req0_b;
    assign div_zero = (sel_fun == 2'b11) && (sel_b == '0);

    // tmo_cnt holds the number of flagless WAIT cycles already spent, so the
    // TMO_CYC-th one is the cycle where it equals TMO_CYC-1.
    assign tmo_last = (tmo_cnt == TMO_W'(TMO_CYC - 1));

    assign alu_en    = (state == ISSUE);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = div_zero ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // The flag is checked before the timeout count, so a flag on
                // the last allowed cycle still yields a good response.
                if (alu_flag || tmo_last) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
            tmo_cnt    <= '0;
            alu_fun    <= 2'b00;
            alu_a      <= '0;
            alu_b      <= '0;
            rsp_id     <= 1'b0;
            rsp_data   <= '0;
            rsp_carry  <= 1'b0;
            rsp_err    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        alu_fun    <= sel_fun;
                        alu_a      <= sel_a;
                        alu_b      <= sel_b;
                        rsp_id     <= grant;
                        last_grant <= grant;
                        tmo_cnt    <= '0;
                        if (div_zero) begin
                            rsp_err   <= 1'b1;
                            rsp_data  <= '1;
                            rsp_carry <= 1'b0;
                        end
                    end
                end
                WAIT: begin
                    if (alu_flag) begin
                        rsp_data  <= alu_out;
                        rsp_carry <= alu_carry;
                        rsp_err   <= 1'b0;
                    end else if (tmo_last) begin
                        rsp_data  <= '0;
                        rsp_carry <= 1'b0;
                        rsp_err   <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + TMO_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
`timescale 1ns/1ps
module tb_alu_cmd_sequencer;

    localparam int W   = 16;
    localparam int TMO = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_fun, req1_fun;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         alu_en;
    logic [1:0]   alu_fun;
    logic [W-1:0] alu_a, alu_b, alu_out;
    logic         alu_carry, alu_flag;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry, rsp_err;
    logic [W-1:0] rsp_data;

    alu_cmd_sequencer #(.WIDTH(W), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_fun(req0_fun),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_fun(req1_fun),
        .req1_a(req1_a), .req1_b(req1_b),
        .alu_en(alu_en), .alu_fun(alu_fun), .alu_a(alu_a), .alu_b(alu_b),
        .alu_out(alu_out), .alu_carry(alu_carry), .alu_flag(alu_flag),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .rsp_carry(rsp_carry), .rsp_err(rsp_err)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Arithmetic of the unit: {carry, result}. Carry is the add carry-out,
    // the sub borrow, or "product overflowed WIDTH" for mul.
    function automatic logic [W:0] ref_op(input logic [1:0] f, input logic [W-1:0] a,
                                          input logic [W-1:0] b);
        logic [2*W-1:0] p;
        logic [W-1:0]   d;
        p = {{W{1'b0}}, a} * {{W{1'b0}}, b};
        d = a - b;
        case (f)
            2'd0:    ref_op = {1'b0, a} + {1'b0, b};
            2'd1:    ref_op = {a < b, d};
            2'd2:    ref_op = {|p[2*W-1:W], p[W-1:0]};
            default: ref_op = {1'b0, a / b};
        endcase
    endfunction

    // ---------------- unit model ----------------
    // unit_lat = cycles after the enable cycle until alu_flag; 0 = never.
    int         unit_lat = 1;
    int         u_cnt;
    logic [W:0] u_hold;
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            u_cnt <= 0; alu_flag <= 1'b0; alu_out <= '0; alu_carry <= 1'b0; u_hold <= '0;
        end else begin
            alu_flag  <= 1'b0;
            alu_out   <= W'($urandom);
            alu_carry <= 1'($urandom);
            if (alu_en) begin
                if (unit_lat == 1) begin
                    alu_flag <= 1'b1;
                    {alu_carry, alu_out} <= ref_op(alu_fun, alu_a, alu_b);
                end else if (unit_lat >= 2) begin
                    u_cnt  <= unit_lat - 1;
                    u_hold <= ref_op(alu_fun, alu_a, alu_b);
                end
            end else if (u_cnt != 0) begin
                u_cnt <= u_cnt - 1;
                if (u_cnt == 1) begin
                    alu_flag <= 1'b1;
                    {alu_carry, alu_out} <= u_hold;
                end
            end
        end
    end

    // ---------------- transaction-level reference ----------------
    bit           busy = 0;
    logic         m_last = 1'b1;
    int           lat_mode = 1;   // <0 random per command, else fixed unit_lat
    int           acc0 = 0, acc1 = 0;
    logic         gq[$];
    logic         e_id, e_err, e_car;
    logic [1:0]   e_fun;
    logic [W-1:0] e_a, e_b, e_data;
    int           e_lat, e_en, en_cnt, age;

    task automatic monitor();
        logic       g;
        logic [W:0] r;
        forever begin
            @(negedge clk);
            if (!rst) begin
                busy   = 0;
                m_last = 1'b1;
            end else if (!busy) begin
                g = (req0_valid && req1_valid) ? ~m_last : req1_valid;
                chk("rdy0", req0_ready, req0_valid && !g);
                chk("rdy1", req1_ready, req1_valid && g);
                chk("rsp_idle", rsp_valid, 0);
                chk("en_idle", alu_en, 0);
                if (req0_valid || req1_valid) begin
                    e_id  = g;
                    e_fun = g ? req1_fun : req0_fun;
                    e_a   = g ? req1_a : req0_a;
                    e_b   = g ? req1_b : req0_b;
                    m_last = g;
                    gq.push_back(g);
                    if (g) acc1++; else acc0++;
                    unit_lat = (lat_mode < 0) ? $urandom_range(0, TMO + 1) : lat_mode;
                    if (e_fun == 2'b11 && e_b == 0) begin
                        e_err = 1; e_data = '1; e_car = 0; e_lat = 1; e_en = 0;
                    end else if (unit_lat == 0 || unit_lat > TMO) begin
                        e_err = 1; e_data = '0; e_car = 0; e_lat = TMO + 2; e_en = 1;
                    end else begin
                        r = ref_op(e_fun, e_a, e_b);
                        e_err = 0; e_data = r[W-1:0]; e_car = r[W]; e_lat = unit_lat + 2; e_en = 1;
                    end
                    busy = 1; age = 0; en_cnt = 0;
                end
            end else begin
                age++;
                chk("rdy_busy", {req0_ready, req1_ready}, 0);
                if (alu_en) en_cnt++;
                if (age == 1 && e_en == 1) begin
                    chk("en_issue", alu_en, 1);
                    chk("alu_fun", alu_fun, e_fun);
                    chk("alu_a", alu_a, e_a);
                    chk("alu_b", alu_b, e_b);
                end
                if (age < e_lat) begin
                    chk("rsp_early", rsp_valid, 0);
                end else begin
                    chk("rsp_valid", rsp_valid, 1);
                    chk("rsp_id", rsp_id, e_id);
                    chk("rsp_data", rsp_data, e_data);
                    chk("rsp_carry", rsp_carry, e_car);
                    chk("rsp_err", rsp_err, e_err);
                    if (rsp_ready) begin
                        chk("en_pulses", en_cnt, e_en);
                        busy = 0;
                    end
                end
            end
        end
    endtask

    // ---------------- stimulus helpers ----------------
    task automatic set_req(input int id, input logic v, input logic [1:0] f,
                           input logic [W-1:0] a, input logic [W-1:0] b);
        if (id == 0) begin
            req0_valid = v; req0_fun = f; req0_a = a; req0_b = b;
        end else begin
            req1_valid = v; req1_fun = f; req1_a = a; req1_b = b;
        end
    endtask

    task automatic send(input int id, input logic [1:0] f, input logic [W-1:0] a,
                        input logic [W-1:0] b);
        int c0;
        c0 = (id == 0) ? acc0 : acc1;
        set_req(id, 1'b1, f, a, b);
        for (int k = 0; k < 300; k++) begin
            @(posedge clk); #1;
            if (((id == 0) ? acc0 : acc1) != c0) break;
        end
        chk("accept_tmo", ((id == 0) ? acc0 : acc1) != c0, 1);
        set_req(id, 1'b0, f, a, b);
    endtask

    task automatic wait_idle();
        for (int k = 0; k < 200 && busy; k++) @(posedge clk);
        #1;
        chk("idle_tmo", busy, 0);
    endtask

    task automatic rand_req(input int id, input int n);
        logic [1:0]   f;
        logic [W-1:0] a, b;
        for (int i = 0; i < n; i++) begin
            repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
            f = 2'($urandom);
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? '0 : W'($urandom);
            send(id, f, a, b);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rnd_done;
        rst = 1'b0; rsp_ready = 1'b1;
        set_req(0, 1'b0, 2'd0, '0, '0);
        set_req(1, 1'b0, 2'd0, '0, '0);
        fork monitor(); join_none

        // reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_alu_en", alu_en, 0);
        chk("rst_alu_a", alu_a, 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_rsp_err", rsp_err, 0);
        #2 rst = 1'b1;

        // add with carry-out, unit answers on the first WAIT cycle
        lat_mode = 1;
        send(0, 2'd0, 16'hFFFF, 16'h0001);
        wait_idle();

        // divide by zero from req1
        send(1, 2'd3, 16'd7, 16'd0);
        wait_idle();

        // both requesters continuously valid -> alternating grants
        gq.delete();
        fork
            begin send(0, 2'd1, 16'd5, 16'd3); send(0, 2'd1, 16'd5, 16'd3); end
            begin send(1, 2'd2, 16'h0100, 16'h0100); send(1, 2'd2, 16'h0100, 16'h0100); end
        join
        wait_idle();
        chk("gq_size", gq.size(), 4);
        for (int i = 0; i < 4 && i < gq.size(); i++) chk("grant_order", gq[i], i % 2);

        // unit never raises its flag -> timeout
        lat_mode = 0;
        send(0, 2'd0, 16'h1234, 16'h0001);
        wait_idle();

        // response backpressure with req0 waiting
        lat_mode = 2;
        rsp_ready = 1'b0;
        send(1, 2'd1, 16'd9, 16'd4);
        for (int k = 0; k < 20 && !rsp_valid; k++) @(negedge clk);
        chk("bp_rsp_seen", rsp_valid, 1);
        @(posedge clk); #1;
        fork
            begin repeat (10) begin @(posedge clk); #1; end rsp_ready = 1'b1; end
            send(0, 2'd0, 16'd1, 16'd2);
        join
        wait_idle();

        // reset during WAIT
        lat_mode = 0;
        send(0, 2'd2, 16'd3, 16'd5);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        chk("arst_rsp_valid", rsp_valid, 0);
        chk("arst_alu_en", alu_en, 0);
        chk("arst_alu_fun", alu_fun, 0);
        chk("arst_alu_a", alu_a, 0);
        chk("arst_alu_b", alu_b, 0);
        chk("arst_rsp_err", rsp_err, 0);
        repeat (2) @(posedge clk);
        #3 rst = 1'b1;
        lat_mode = 1;
        fork
            send(0, 2'd0, 16'd10, 16'd20);
            send(1, 2'd1, 16'd20, 16'd10);
            begin
                @(negedge clk);
                chk("post_rst_rdy0", req0_ready, 1);
                chk("post_rst_rdy1", req1_ready, 0);
            end
        join
        wait_idle();

        // randomized traffic with random unit latency and response stalls
        lat_mode = -1;
        rnd_done = 0;
        fork
            begin
                fork rand_req(0, 30); rand_req(1, 30); join
                rnd_done = 1;
            end
            begin
                while (!rnd_done) begin
                    @(posedge clk); #1;
                    rsp_ready = ($urandom_range(0, 3) != 0);
                end
                rsp_ready = 1'b1;
            end
        join
        wait_idle();
        repeat (3) @(posedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
